// File: rtl/shared_reg_bank_arb_if.sv
// Write-request bus shared by the requesters of shared_reg_bank_arb.
//   req_valid   per-requester write request
//   req_lock    per-requester burst lock (keep grant after this write)
//   req_addr    flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data    flattened data, requester i at [i*DATA_W +: DATA_W]
//   req_ready   one-hot write accept
//   grant_valid high while a requester holds the grant
//   grant_id    index of current/last winner
// master = requester side, slave = arbiter side.
interface shared_reg_bank_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, grant_valid, grant_id
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, grant_valid, grant_id
    );
endinterface

// File: rtl/shared_reg_bank_arb.sv
// Round-robin arbiter and write sequencer for a shared register bank.
// Requesters compete through a valid/ready handshake on the bus interface;
// the winner may hold the bank for up to MAX_BURST consecutive locked writes.
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   bus       slave side of shared_reg_bank_arb_if (requests, ready, grant)
//   rd_addr   combinational read address
//   rd_data   bank[rd_addr], no write bypass
//   wr_count  total committed writes, wraps 0xFFFF -> 0
module shared_reg_bank_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    shared_reg_bank_arb_if.slave      bus,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic [15:0]               wr_count
);
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [3:0]          burst_cnt_q, burst_cnt_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [DATA_W-1:0]   bank_q [NUM_REGS];

    logic [ID_W-1:0]     winner;
    logic                any_valid;
    logic                commit;
    logic                keep_grant;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        int unsigned idx;
        winner    = rr_ptr_q;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(rr_ptr_q) + off) % NUM_REQ;
            if (!any_valid && bus.req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

    assign commit  = (state_q == GRANT) && bus.req_valid[grant_id_q];
    assign wr_addr = bus.req_addr[32'(grant_id_q) * ADDR_W +: ADDR_W];
    assign wr_data = bus.req_data[32'(grant_id_q) * DATA_W +: DATA_W];

    // Lock only extends the grant while the post-commit beat count stays below MAX_BURST.
    assign keep_grant = bus.req_lock[grant_id_q] &&
                        (({1'b0, burst_cnt_q} + 5'd1) < 5'(MAX_BURST));

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_id_d      = grant_id_q;
        burst_cnt_d     = burst_cnt_q;
        wr_count_d      = wr_count_q;
        bus.req_ready   = '0;
        bus.grant_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_id_d  = winner;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                bus.grant_valid           = 1'b1;
                bus.req_ready[grant_id_q] = 1'b1;
                if (commit) begin
                    wr_count_d  = wr_count_q + 16'd1;
                    rr_ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (!keep_grant) begin
                        state_d = IDLE;
                    end
                end else begin
                    // Winner withdrew its request: release without writing.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            wr_count_q  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            wr_count_q  <= wr_count_d;
            if (commit) begin
                bank_q[wr_addr] <= wr_data;
            end
        end
    end

    assign bus.grant_id = grant_id_q;
    assign rd_data      = bank_q[rd_addr];
    assign wr_count     = wr_count_q;

endmodule

// File: doc/shared_reg_bank_arb.md
Name: shared_reg_bank_arb

Overview:
- Round-robin arbiter and write sequencer for a shared bank of D-flip-flop registers (async active-low reset style).
- NUM_REQ requesters compete for write access through a valid/ready handshake.
- A combinational read port exposes any register.
- Optional lock lets the current winner hold the bank for a bounded burst.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, register width in bits.
- ADDR_W, 2, register address width; bank holds 2**ADDR_W registers.
- MAX_BURST, 4, maximum consecutive locked writes before forced release (1..15).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_lock  in  NUM_REQ  per-requester burst lock; high = keep grant after this write.
- req_addr  in  NUM_REQ*ADDR_W  flattened write addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  flattened write data; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot write accept; at most one bit high.
- grant_valid  out  1  high while in GRANT state.
- grant_id  out  $clog2(NUM_REQ)  index of current/last winner.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  bank[rd_addr], combinational.
- wr_count  out  16  total committed writes, wraps at 0xFFFF -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - All bank registers = 0; state = IDLE; rr_ptr = 0; grant_id = 0; grant_valid = 0.
  - req_ready = 0; burst_cnt = 0; wr_count = 0.
  - Deassertion is synchronised by the instantiating design.
- State IDLE:
  - req_ready = 0, grant_valid = 0.
  - If any req_valid=1: winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On the winning edge: grant_id <= winner, burst_cnt <= 0, state <= GRANT.
  - No valid: stay IDLE.
- State GRANT: grant_valid = 1; req_ready[grant_id] = 1 combinationally, all other bits 0.
- Handshake: commits on an edge where req_valid[g] && req_ready[g], with g = grant_id. At that edge:
  - bank[req_addr_g] <= req_data_g.
  - wr_count <= wr_count + 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - burst_cnt <= burst_cnt + 1.
- After a commit:
  - If req_lock[g]=1 and burst_cnt+1 < MAX_BURST: stay GRANT, same g.
  - Otherwise: state <= IDLE.
- Abandon: in GRANT with req_valid[g]=0 -> IDLE next edge, no write, rr_ptr unchanged.
- Latency and throughput:
  - req_valid sampled at edge E0 -> req_ready high in cycle after E0 -> write at edge E1 -> rd_data reflects it after E1.
  - Unlocked throughput: 1 write per 2 cycles.
  - Locked throughput: 1 write per cycle for up to MAX_BURST writes.
- Fairness:
  - After a forced release at MAX_BURST, rr_ptr already points past g, so other valid requesters win first.
  - The releasing requester is re-granted only if it is the sole requester.
- Read-during-write: rd_data shows the old value in the write cycle and the new value after the edge; no bypass.
- Same-address back-to-back locked writes: last write wins.
- Reset mid-burst: everything returns to reset values immediately; no partial write.
- Requests for non-granted requesters are held off (req_ready=0); the arbiter never drops them.

Test Plan:
- Reset then single write:
  - Stimulus: req_valid=4'b0010, addr1=2, data1=0xA5.
  - Response: req_ready=4'b0010 one cycle later; bank[2]=0xA5 (rd_addr=2 -> rd_data=0xA5); wr_count=1; return to IDLE.
- Round-robin across all requesters:
  - Stimulus: all four req_valid held high, no lock, each writing addr=i, data=0x10+i.
  - Response: grant order 0,1,2,3,0; bank = {0x13,0x12,0x11,0x10} (reg3..reg0); 8 cycles for 4 writes.
- Burst limit:
  - Stimulus: requester 2 with lock=1, valid held for 6 beats, data 0x01..0x06 to addr 0; requester 0 valid throughout.
  - Response: 4 consecutive commits (bank[0]=0x04), then release; requester 0 granted next.
- Abandon:
  - Stimulus: requester 3 valid for one cycle only, dropped during GRANT.
  - Response: no bank change, wr_count unchanged, IDLE next cycle, rr_ptr unchanged.
- Async reset mid-burst:
  - Stimulus: reset pulled low between clock edges during a locked burst.
  - Response: bank all 0, req_ready=0, grant_valid=0, wr_count=0 immediately, without a clock edge.
- wr_count wrap:
  - Stimulus: force wr_count to 0xFFFF, then one write.
  - Response: wr_count=0x0000.
